// File: rtl/data_mem_responder.sv
// MEM-stage data-memory responder: accepts one load/store per request, inserts
// WAIT_STATES stall cycles, then performs a big-endian byte/word access on an internal array.
module data_mem_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MEM_enable,
  input  logic                  MEM_load,
  input  logic                  MEM_size,
  input  logic [ADDR_WIDTH-1:0] MEM_address,
  input  logic [31:0]           MEM_data_in,
  output logic [31:0]           MEM_data_out,
  output logic                  MEM_done,
  output logic                  MEM_stall,
  output logic                  MEM_align_err,
  output logic [1:0]            dbg_state
);

  // Handshake: MEM_enable is a request that is accepted only in IDLE. MEM_stall
  // is the inverse of ready: while it is high the requester must hold EX_MEM.
  // Completion is MEM_done, a single-cycle pulse that coincides with stall low.

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic                    lat_load;
  logic                    lat_size;
  logic [ADDR_WIDTH-1:0]   lat_addr;
  logic [31:0]             lat_data;

  logic [7:0]              mem [0:DEPTH-1];

  logic                    acc_load;
  logic                    acc_size;
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [31:0]             acc_data;
  logic [ADDR_WIDTH-1:0]   addr_b0;
  logic [ADDR_WIDTH-1:0]   addr_b1;
  logic [ADDR_WIDTH-1:0]   addr_b2;
  logic [ADDR_WIDTH-1:0]   addr_b3;
  logic [31:0]             rd_word;
  logic [31:0]             rd_byte;
  logic                    commit;

  // With zero wait states the access happens straight out of IDLE, before the
  // request fields have been latched, so take them from the inputs there.
  always_comb begin
    acc_load = lat_load;
    acc_size = lat_size;
    acc_addr = lat_addr;
    acc_data = lat_data;
    if (state == ST_IDLE) begin
      acc_load = MEM_load;
      acc_size = MEM_size;
      acc_addr = MEM_address;
      acc_data = MEM_data_in;
    end
  end

  always_comb begin
    addr_b0 = {acc_addr[ADDR_WIDTH-1:2], 2'b00};
    addr_b1 = {acc_addr[ADDR_WIDTH-1:2], 2'b01};
    addr_b2 = {acc_addr[ADDR_WIDTH-1:2], 2'b10};
    addr_b3 = {acc_addr[ADDR_WIDTH-1:2], 2'b11};
    rd_word = {mem[addr_b0], mem[addr_b1], mem[addr_b2], mem[addr_b3]};
    rd_byte = {24'd0, mem[acc_addr]};
  end

  // Asserted in the cycle whose closing edge enters DONE.
  always_comb begin
    commit = 1'b0;
    if (!Reset) begin
      if (state == ST_IDLE && MEM_enable && WAIT_STATES == 0) begin
        commit = 1'b1;
      end else if (state == ST_WAIT && cnt == 4'd0) begin
        commit = 1'b1;
      end
    end
  end

  always_comb begin
    MEM_stall = 1'b0;
    if (!Reset) begin
      MEM_stall = (state == ST_IDLE && MEM_enable) || (state == ST_WAIT);
    end
  end

  assign dbg_state = state;

  // Array contents deliberately survive reset.
  always_ff @(posedge Clk) begin
    if (commit && !acc_load) begin
      if (acc_size) begin
        mem[acc_addr] <= acc_data[7:0];
      end else begin
        mem[addr_b0] <= acc_data[31:24];
        mem[addr_b1] <= acc_data[23:16];
        mem[addr_b2] <= acc_data[15:8];
        mem[addr_b3] <= acc_data[7:0];
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state         <= ST_IDLE;
      cnt           <= 4'd0;
      lat_load      <= 1'b0;
      lat_size      <= 1'b0;
      lat_addr      <= '0;
      lat_data      <= 32'd0;
      MEM_data_out  <= 32'd0;
      MEM_done      <= 1'b0;
      MEM_align_err <= 1'b0;
    end else begin
      MEM_done      <= 1'b0;
      MEM_align_err <= 1'b0;
      if (commit) begin
        MEM_done      <= 1'b1;
        MEM_align_err <= !acc_size && (acc_addr[1:0] != 2'b00);
        if (acc_load) begin
          MEM_data_out <= acc_size ? rd_byte : rd_word;
        end
      end
      case (state)
        ST_IDLE: begin
          if (MEM_enable) begin
            lat_load <= MEM_load;
            lat_size <= MEM_size;
            lat_addr <= MEM_address;
            lat_data <= MEM_data_in;
            if (WAIT_STATES > 0) begin
              state <= ST_WAIT;
              cnt   <= WAIT_LOAD;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
